// File: rtl/vc_pkg.sv
// Shared victim-cache geometry and block/tag types used by the eviction path.
package vc_pkg;
    localparam int BLOCK_W     = 512;
    localparam int PTAG_W      = 44;
    localparam int OFFSET_W    = 12;
    localparam int VC_WAYS     = 8;
    localparam int VC_LAT      = 3;
    // Every way still holds its reset-value block until this many writes have landed.
    localparam int FILL_WRITES = VC_WAYS;

    typedef logic [BLOCK_W-1:0]  block_t;
    typedef logic [PTAG_W-1:0]   ptag_t;
    typedef logic [OFFSET_W-1:0] offset_t;
endpackage

// File: rtl/vc_wb_fifo.sv
// Return buffer for blocks displaced from the victim cache; head is presented combinationally.
module vc_wb_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/vc_evict_issuer.sv
// Issues L1 evictions as victim-cache writes and queues the displaced blocks for writeback.
// Define VC_FILL_FILTER_EN to drop the reset-value victims returned by the first fill writes.
module vc_evict_issuer
    import vc_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ev_valid,
    output logic                ev_ready,
    input  logic [PTAG_W-1:0]   ev_ptag,
    input  logic [OFFSET_W-1:0] ev_offset,
    input  logic [BLOCK_W-1:0]  ev_data,
    output logic                vc_write_en,
    output logic [OFFSET_W-1:0] vc_page_offset,
    output logic [BLOCK_W-1:0]  vc_data_in,
    output logic [PTAG_W-1:0]   vc_phys_tag_ret,
    output logic                vc_tlb_miss,
    input  logic [BLOCK_W-1:0]  vc_block_out,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [BLOCK_W-1:0]  wb_data,
    output logic                busy
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic             accept;
    logic             push;
    logic             vld_p0;
    logic             vld_p1;
    logic             vld_p2;
    ptag_t            tag_p0;
    logic [2:0]       in_flight;
    logic [3:0]       credit_used;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;

    // A credit is held from acceptance until the block leaves the FIFO (or is filtered).
    assign in_flight   = 3'(vc_write_en) + 3'(vld_p0) + 3'(vld_p1) + 3'(vld_p2);
    assign credit_used = 4'(in_flight) + 4'(fifo_count);
    assign ev_ready    = !reset && (credit_used < 4'(BUF_DEPTH));
    assign accept      = ev_valid && ev_ready;
    assign vc_tlb_miss = 1'b0;
    assign wb_valid    = !fifo_empty;
    assign busy        = (in_flight != 3'd0) || !fifo_empty;

    // Stage T: write command registered from the transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vc_write_en <= 1'b0;
        else       vc_write_en <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            vc_page_offset <= ev_offset;
            vc_data_in     <= ev_data;
            tag_p0         <= ev_ptag;
        end
    end

    // Stages T+1..T+3: tag return and victim-latency tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            vld_p2          <= 1'b0;
            vc_phys_tag_ret <= '0;
        end else begin
            vld_p0 <= vc_write_en;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vc_write_en) vc_phys_tag_ret <= tag_p0;
        end
    end

`ifdef VC_FILL_FILTER_EN
    logic [3:0] fill_cnt;
    logic       drop_p0;
    logic       drop_p1;
    logic       drop_p2;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt <= '0;
            drop_p0  <= 1'b0;
            drop_p1  <= 1'b0;
            drop_p2  <= 1'b0;
        end else begin
            if (vc_write_en) fill_cnt <= sat_inc(fill_cnt);
            drop_p0 <= vc_write_en && (fill_cnt < 4'(FILL_WRITES));
            drop_p1 <= drop_p0;
            drop_p2 <= drop_p1;
        end
    end

    assign push = vld_p2 && !drop_p2;
`else
    assign push = vld_p2;
`endif

    // Capture at the end of T+3 and queue for writeback
    vc_wb_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (BUF_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (vc_block_out),
        .pop       (wb_valid && wb_ready),
        .head      (wb_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_vc_evict_issuer.sv
// Scoreboard bench: victim cache modelled as an 8-entry oldest-first store, credits as a counter.
module tb_vc_evict_issuer;
    localparam int BUF_DEPTH = 4;
`ifdef VC_FILL_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ev_valid = 1'b0;
    logic         ev_ready;
    logic [43:0]  ev_ptag = '0;
    logic [11:0]  ev_offset = '0;
    logic [511:0] ev_data = '0;
    logic         vc_write_en;
    logic [11:0]  vc_page_offset;
    logic [511:0] vc_data_in;
    logic [43:0]  vc_phys_tag_ret;
    logic         vc_tlb_miss;
    logic [511:0] vc_block_out = '0;
    logic         wb_valid;
    logic         wb_ready = 1'b0;
    logic [511:0] wb_data;
    logic         busy;

    vc_evict_issuer #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_ptag(ev_ptag), .ev_offset(ev_offset), .ev_data(ev_data),
        .vc_write_en(vc_write_en), .vc_page_offset(vc_page_offset), .vc_data_in(vc_data_in),
        .vc_phys_tag_ret(vc_phys_tag_ret), .vc_tlb_miss(vc_tlb_miss), .vc_block_out(vc_block_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .busy(busy)
    );

    typedef struct { int cyc; logic [43:0] ptag; logic [11:0] off; logic [511:0] data; } acc_t;
    typedef struct { logic [511:0] data; int avail; } wbe_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           outstanding = 0;
    int           widx = 0;
    int           acc_count = 0;
    bit           tag_due = 1'b0;
    logic [43:0]  tag_exp = '0;
    acc_t         acc_q[$];
    wbe_t         exp_q[$];
    logic [511:0] lru[$];
    logic [511:0] sched[int];
    bit           drop_at[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic report(input string name, input bit ok, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic chk_b(input string name, input bit act, input bit exp);
        report(name, act === exp, 512'(act), 512'(exp));
    endtask
    task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
        report(name, act === exp, act, exp);
    endtask
    task automatic chk_i(input string name, input int act, input int exp);
        report(name, act == exp, 512'(act), 512'(exp));
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Victim cache stand-in: returns each write's displaced block three cycles later, noise otherwise.
    always @(posedge clk) begin
        #1;
        if (sched.exists(cyc)) begin
            vc_block_out = sched[cyc];
            sched.delete(cyc);
        end else begin
            vc_block_out = rand512();
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        acc_t         a;
        logic [511:0] victim;
        bit           exp_v;
        if (reset) begin
            chk_b("rst_write_en", vc_write_en, 1'b0);
            chk_b("rst_tlb_miss", vc_tlb_miss, 1'b0);
            chk_w("rst_tag_ret", 512'(vc_phys_tag_ret), '0);
            chk_b("rst_wb_valid", wb_valid, 1'b0);
            chk_b("rst_busy", busy, 1'b0);
            chk_b("rst_ev_ready", ev_ready, 1'b0);
            acc_q.delete();
            exp_q.delete();
            sched.delete();
            drop_at.delete();
            lru.delete();
            for (int i = 0; i < 8; i++) lru.push_back('0);
            outstanding = 0;
            widx = 0;
            tag_due = 1'b0;
        end else begin
            chk_b("tlb_miss", vc_tlb_miss, 1'b0);
            chk_b("ev_ready", ev_ready, outstanding < BUF_DEPTH);
            chk_b("busy", busy, outstanding != 0);
            if (tag_due) chk_w("phys_tag_ret", 512'(vc_phys_tag_ret), 512'(tag_exp));
            tag_due = 1'b0;
            if (vc_write_en) begin
                if (acc_q.size() == 0 || acc_q[0].cyc != cyc - 1) begin
                    chk_b("write_unexpected", vc_write_en, 1'b0);
                end else begin
                    a = acc_q.pop_front();
                    chk_w("page_offset", 512'(vc_page_offset), 512'(a.off));
                    chk_w("data_in", vc_data_in, a.data);
                    tag_due = 1'b1;
                    tag_exp = a.ptag;
                    widx++;
                    victim = lru.pop_front();
                    lru.push_back(a.data);
                    sched[cyc + 3] = victim;
                    if (FILTER && widx <= 8) drop_at[cyc + 3] = 1'b1;
                    else exp_q.push_back('{victim, cyc + 4});
                end
            end else if (acc_q.size() != 0 && acc_q[0].cyc == cyc - 1) begin
                chk_b("write_missing", vc_write_en, 1'b1);
                void'(acc_q.pop_front());
            end
            exp_v = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
            chk_b("wb_valid", wb_valid, exp_v);
            if (wb_valid && exp_v) begin
                chk_w("wb_data", wb_data, exp_q[0].data);
                if (wb_ready) begin
                    void'(exp_q.pop_front());
                    outstanding--;
                end
            end
            if (drop_at.exists(cyc)) begin
                outstanding--;
                drop_at.delete(cyc);
            end
            if (ev_valid && ev_ready) begin
                acc_q.push_back('{cyc, ev_ptag, ev_offset, ev_data});
                outstanding++;
                acc_count++;
            end
        end
    end

    task automatic send(input logic [43:0] p, input logic [11:0] o, input logic [511:0] d);
        bit ok;
        ok = 1'b0;
        ev_valid = 1'b1;
        ev_ptag = p;
        ev_offset = o;
        ev_data = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (ev_ready) ok = 1'b1;
        end
        chk_b("send_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (acc_q.size() == 0) && (outstanding == 0);
        end
        chk_b("drain_timeout", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        wb_ready = 1'b1;
        send(44'h1, 12'h040, {64{8'hAA}});
        ev_valid = 1'b0;
        drain();

        do_reset();
        for (int k = 0; k < 12; k++) send(44'(k + 100), 12'(k), 512'(k));
        ev_valid = 1'b0;
        drain();

        wb_ready = 1'b0;
        base = acc_count;
        ev_valid = 1'b1;
        repeat (20) begin
            ev_data = rand512();
            ev_ptag = 44'({$urandom, $urandom});
            ev_offset = 12'($urandom);
            @(posedge clk);
            #1;
        end
        chk_i("bp_accepts", acc_count - base, BUF_DEPTH);
        @(negedge clk);
        chk_b("bp_ready_low", ev_ready, 1'b0);
        @(posedge clk);
        #1 wb_ready = 1'b1;
        @(posedge clk);
        #1 wb_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_i("bp_one_more", acc_count - base, BUF_DEPTH + 1);
        ev_valid = 1'b0;
        wb_ready = 1'b1;
        drain();

        repeat (300) begin
            ev_valid = ($urandom_range(0, 3) != 0);
            ev_ptag = 44'({$urandom, $urandom});
            ev_offset = 12'($urandom);
            ev_data = rand512();
            wb_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        ev_valid = 1'b0;
        wb_ready = 1'b1;
        drain();

        wb_ready = 1'b0;
        send(44'hABC, 12'h123, rand512());
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_b("post_rst_ready", ev_ready, 1'b1);
        chk_b("post_rst_busy", busy, 1'b0);
        chk_b("post_rst_wb_valid", wb_valid, 1'b0);
        wb_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk_b("post_rst_idle_busy", busy, 1'b0);
        chk_b("post_rst_idle_wb", wb_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
